// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: one 64-byte line read/write at a time, open-page policy,
// per-bank open-row tracking and periodic all-bank refresh serviced from IDLE.
module ddr4_cmd_sequencer #(
  parameter int PADDR_BITS         = 19,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int WIDTH              = 64,
  parameter int BURST_LEN          = 8,
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int REFRESH_CYCLE      = 5120,
  parameter int REFRESH_LATENCY    = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic [PADDR_BITS-1:0]      req_addr_in,
  input  logic                       req_we_in,
  input  logic [BURST_LEN*WIDTH-1:0] req_wdata_in,
  output logic                       resp_valid_out,
  input  logic                       resp_ready_in,
  output logic [BURST_LEN*WIDTH-1:0] resp_data_out,
  output logic                       cs_N_out,
  output logic                       act_out,
  output logic [16:0]                addr_out,
  output logic [1:0]                 bg_out,
  output logic [1:0]                 ba_out,
  output logic [WIDTH-1:0]           dq_out,
  output logic                       dq_oe_out,
  input  logic [WIDTH-1:0]           dq_in
);

  localparam int LINE_W    = BURST_LEN * WIDTH;
  localparam int ADDR_W    = 17;
  localparam int BANK_BITS = 3;
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int LINE_LSB  = 6;
  localparam int BANK_LSB  = LINE_LSB + 1;
  localparam int ROW_LSB   = BANK_LSB + BANK_BITS;
  localparam int BEAT_W    = $clog2(BURST_LEN);
  localparam int CNT_MAX   = CAS_LATENCY + BURST_LEN + REFRESH_LATENCY
                           + ACTIVATION_LATENCY + PRECHARGE_LATENCY;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int REF_W     = $clog2(REFRESH_CYCLE);

  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_RW,
    S_DATA,
    S_RESP,
    S_RPRE,
    S_RPRE_WAIT,
    S_REF,
    S_REF_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REF_W-1:0]     ref_cnt_q;
  logic                 ref_pending_q;
  logic [NUM_BANKS-1:0] open_valid_q;
  logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];

  logic [ROW_BITS-1:0]  row_q;
  logic [BANK_BITS-1:0] bank_q;
  logic                 line_q;
  logic                 we_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [LINE_W-1:0]    rdata_q;

  logic [ROW_BITS-1:0]  row_in;
  logic [BANK_BITS-1:0] bank_in;
  logic                 accept;
  logic                 row_hit;
  logic                 bank_open;
  logic                 any_open;
  logic                 in_burst;
  logic [BEAT_W-1:0]    beat_idx;
  logic                 ref_done;
  logic                 unused_addr_bits;

  assign row_in    = req_addr_in[ROW_LSB +: ROW_BITS];
  assign bank_in   = req_addr_in[BANK_LSB +: BANK_BITS];
  assign unused_addr_bits = ^{req_addr_in[LINE_LSB-1:0],
                              req_addr_in[PADDR_BITS-1:ROW_LSB+ROW_BITS]};

  assign bank_open = open_valid_q[bank_in];
  assign row_hit   = bank_open && (open_row_q[bank_in] == row_in);
  assign any_open  = |open_valid_q;
  assign accept    = (state_q == S_IDLE) && !ref_pending_q && req_valid_in;

  // Data beats occupy counter values CAS_LATENCY .. CAS_LATENCY+BURST_LEN-1 after RD/WR.
  assign in_burst  = (state_q == S_DATA) && (cnt_q >= CNT_W'(CAS_LATENCY));
  assign beat_idx  = BEAT_W'(cnt_q - CNT_W'(CAS_LATENCY));
  assign ref_done  = (state_q == S_REF_WAIT) && (cnt_q == CNT_W'(REFRESH_LATENCY - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      open_valid_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ref_cnt_q == REF_W'(REFRESH_CYCLE - 1)) begin
        ref_cnt_q     <= '0;
        ref_pending_q <= 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + REF_W'(1);
        if (ref_done) ref_pending_q <= 1'b0;
      end
      case (state_q)
        S_ACT:   open_valid_q[bank_q] <= 1'b1;
        S_PRE:   open_valid_q[bank_q] <= 1'b0;
        S_RPRE:  open_valid_q         <= '0;
        default: if (ref_done) open_valid_q <= '0;
      endcase
    end
  end

  // NOTE: request payload, row table contents and read line are only observed while
  // qualified by reset-cleared control state, so they are plain registers without reset.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      row_q   <= row_in;
      bank_q  <= bank_in;
      line_q  <= req_addr_in[LINE_LSB];
      we_q    <= req_we_in;
      wdata_q <= req_wdata_in;
    end
    if (state_q == S_ACT) open_row_q[bank_q] <= row_q;
    if (in_burst && !we_q) rdata_q[int'(beat_idx)*WIDTH +: WIDTH] <= dq_in;
  end

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pending_q)     state_d = any_open ? S_RPRE : S_REF;
        else if (req_valid_in) state_d = row_hit ? S_RW : (bank_open ? S_PRE : S_ACT);
      end
      S_PRE: begin
        state_d = S_PRE_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_PRE_WAIT: begin
        if (cnt_q == CNT_W'(PRECHARGE_LATENCY - 1)) state_d = S_ACT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_ACT: begin
        state_d = S_ACT_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_ACT_WAIT: begin
        if (cnt_q == CNT_W'(ACTIVATION_LATENCY - 1)) state_d = S_RW;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_RW: begin
        state_d = S_DATA;
        cnt_d   = CNT_W'(1);
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CAS_LATENCY + BURST_LEN - 1)) state_d = S_RESP;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_RESP: begin
        if (resp_ready_in) state_d = S_IDLE;
      end
      S_RPRE: begin
        state_d = S_RPRE_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_RPRE_WAIT: begin
        if (cnt_q == CNT_W'(PRECHARGE_LATENCY - 1)) state_d = S_REF;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_REF: begin
        state_d = S_REF_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_REF_WAIT: begin
        if (ref_done) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command bus: driven only in the single command-issue state, otherwise idle (CS_n high).
  always_comb begin
    logic [COL_BITS-1:0] col;
    col      = '0;
    col[BEAT_W] = line_q;
    cs_N_out = 1'b1;
    act_out  = 1'b0;
    addr_out = '0;
    bg_out   = '0;
    ba_out   = '0;
    case (state_q)
      S_ACT: begin
        cs_N_out = 1'b0;
        act_out  = 1'b1;
        addr_out = ADDR_W'(row_q);
        bg_out   = {1'b0, bank_q[2]};
        ba_out   = bank_q[1:0];
      end
      S_PRE: begin
        cs_N_out        = 1'b0;
        addr_out[16:14] = CMD_PRE;
        bg_out          = {1'b0, bank_q[2]};
        ba_out          = bank_q[1:0];
      end
      S_RW: begin
        cs_N_out                = 1'b0;
        addr_out[16:14]         = we_q ? CMD_WR : CMD_RD;
        addr_out[COL_BITS-1:0]  = col;
        bg_out                  = {1'b0, bank_q[2]};
        ba_out                  = bank_q[1:0];
      end
      S_RPRE: begin
        cs_N_out        = 1'b0;
        addr_out[16:14] = CMD_PRE;
        addr_out[10]    = 1'b1;
      end
      S_REF: begin
        cs_N_out        = 1'b0;
        addr_out[16:14] = CMD_REF;
      end
      default: ;
    endcase
  end

  assign req_ready_out  = (state_q == S_IDLE) && !ref_pending_q && !rst_in;
  assign resp_valid_out = (state_q == S_RESP);
  assign resp_data_out  = (state_q == S_RESP && !we_q) ? rdata_q : '0;
  assign dq_oe_out      = in_burst && we_q;
  assign dq_out         = dq_oe_out ? wdata_q[int'(beat_idx)*WIDTH +: WIDTH] : '0;

endmodule
